// File: rtl/iob_mem_arbiter.sv
// iob_mem_arbiter: two-master to one-slave memory arbiter on the IOb native bus.
// Master 0 is the instruction bus and master 1 is the data bus.
// Ties go round-robin through a 1-bit last_grant.
// Each transaction passes IDLE -> BUSY -> RESP, and every output is registered.
module iob_mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   // master 0 (instruction bus)
   input  logic                  m0_valid,
   input  logic [ADDR_W-1:0]     m0_addr,
   input  logic [DATA_W-1:0]     m0_wdata,
   input  logic [DATA_W/8-1:0]   m0_wstrb,
   output logic [DATA_W-1:0]     m0_rdata,
   output logic                  m0_ready,
   // master 1 (data bus)
   input  logic                  m1_valid,
   input  logic [ADDR_W-1:0]     m1_addr,
   input  logic [DATA_W-1:0]     m1_wdata,
   input  logic [DATA_W/8-1:0]   m1_wstrb,
   output logic [DATA_W-1:0]     m1_rdata,
   output logic                  m1_ready,
   // shared memory
   output logic                  s_valid,
   output logic [ADDR_W-1:0]     s_addr,
   output logic [DATA_W-1:0]     s_wdata,
   output logic [DATA_W/8-1:0]   s_wstrb,
   input  logic [DATA_W-1:0]     s_rdata,
   input  logic                  s_ready
);

   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]        state_q,      state_d;
   logic              grant_q,      grant_d;
   logic              last_grant_q, last_grant_d;
   logic              s_valid_q,    s_valid_d;
   logic [ADDR_W-1:0] s_addr_q,     s_addr_d;
   logic [DATA_W-1:0] s_wdata_q,    s_wdata_d;
   logic [STRB_W-1:0] s_wstrb_q,    s_wstrb_d;
   logic              m0_ready_q,   m0_ready_d;
   logic              m1_ready_q,   m1_ready_d;
   logic [DATA_W-1:0] m0_rdata_q,   m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q,   m1_rdata_d;
   logic              winner;

   // Next-state and next-output logic; every register holds its value unless a state acts on it
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      s_valid_d    = s_valid_q;
      s_addr_d     = s_addr_q;
      s_wdata_d    = s_wdata_q;
      s_wstrb_d    = s_wstrb_q;
      m0_ready_d   = 1'b0;
      m1_ready_d   = 1'b0;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      winner       = 1'b0;

      case (state_q)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               // On a tie the master served less recently wins; a lone requester always wins
               if (m0_valid && m1_valid) begin
                  winner = ~last_grant_q;
               end else begin
                  winner = m1_valid;
               end
               grant_d   = winner;
               s_valid_d = 1'b1;
               s_addr_d  = winner ? m1_addr  : m0_addr;
               s_wdata_d = winner ? m1_wdata : m0_wdata;
               s_wstrb_d = winner ? m1_wstrb : m0_wstrb;
               state_d   = BUSY;
            end else begin
               s_valid_d = 1'b0;
            end
         end

         BUSY: begin
            // Hold the request on s_* until memory answers; there is no timeout
            if (s_ready) begin
               if (grant_q) begin
                  m1_rdata_d = s_rdata;
                  m1_ready_d = 1'b1;
               end else begin
                  m0_rdata_d = s_rdata;
                  m0_ready_d = 1'b1;
               end
               s_valid_d    = 1'b0;
               last_grant_d = grant_q;
               state_d      = RESP;
            end
         end

         RESP: begin
            // The ready pulse is visible during this cycle; s_ready is ignored here
            state_d = IDLE;
         end

         default: begin
            s_valid_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         s_valid_q    <= 1'b0;
         s_addr_q     <= '0;
         s_wdata_q    <= '0;
         s_wstrb_q    <= '0;
         m0_ready_q   <= 1'b0;
         m1_ready_q   <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         s_valid_q    <= s_valid_d;
         s_addr_q     <= s_addr_d;
         s_wdata_q    <= s_wdata_d;
         s_wstrb_q    <= s_wstrb_d;
         m0_ready_q   <= m0_ready_d;
         m1_ready_q   <= m1_ready_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   assign s_valid  = s_valid_q;
   assign s_addr   = s_addr_q;
   assign s_wdata  = s_wdata_q;
   assign s_wstrb  = s_wstrb_q;
   assign m0_ready = m0_ready_q;
   assign m1_ready = m1_ready_q;
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;

endmodule
